// File: rtl/matrix_writeback_if.sv
// Bundles the writeback request, memory write port and status lines of matrix_writeback.
// slave = the writeback block itself, master = the coprocessor/memory side that drives it.
interface matrix_writeback_if #(
   parameter int DIM    = 5,
   parameter int EW     = 8,
   parameter int AW     = 8,
   parameter int DATA_W = DIM*DIM*EW
);
   logic              wb_valid;
   logic [DATA_W-1:0] wb_result;
   logic [2:0]        wb_size;
   logic [AW-1:0]     wb_base;
   logic              wb_ready;

   logic              mem_wr_en;
   logic [AW-1:0]     mem_wr_addr;
   logic [EW-1:0]     mem_wr_data;
   logic              mem_ready;

   logic              busy;
   logic              done;
   logic              overflow;
   logic              ovf_clr;

   modport master (
      output wb_valid, wb_result, wb_size, wb_base, mem_ready, ovf_clr,
      input  wb_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, overflow
   );

   modport slave (
      input  wb_valid, wb_result, wb_size, wb_base, mem_ready, ovf_clr,
      output wb_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, overflow
   );
endinterface

// File: rtl/matrix_writeback.sv
// Unpacks a DIMxDIM result matrix and writes the active n x n block bytewise, row-major, at base + row*DIM + col.
// Latency: first write 1 cycle after acceptance, then one element per mem_ready cycle, done pulse after the last.
// Backpressure: addr/data held while mem_ready=0; requests dropped when not ready set sticky overflow (MATRIX_WB_SKID_EN adds a 1-entry park buffer).
module matrix_writeback #(
   parameter int DIM    = 5,
   parameter int EW     = 8,
   parameter int AW     = 8,
   parameter int DATA_W = DIM*DIM*EW
) (
   input  logic             clk,
   input  logic             reset,
   matrix_writeback_if.slave bus
);

   localparam int IW = $clog2(DIM*DIM);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]        state;
   logic [DATA_W-1:0] res_q;
   logic [AW-1:0]     base_q;
   logic [2:0]        n_q;
   logic [2:0]        row_q;
   logic [2:0]        col_q;
   logic              overflow_q;

   logic              in_write;
   logic              last_col;
   logic              last_row;
   logic [IW-1:0]     idx;

   logic              ld_go;
   logic [DATA_W-1:0] ld_res;
   logic [AW-1:0]     ld_base;
   logic [2:0]        ld_size;
   logic              drop;

   // Size 0 or anything above DIM means a full matrix.
   function automatic logic [2:0] eff_n(input logic [2:0] sz);
      if (sz == 3'd0 || int'(sz) > DIM)
         return 3'(DIM);
      return sz;
   endfunction

`ifdef MATRIX_WB_SKID_EN
   logic              pend_vld;
   logic [DATA_W-1:0] pend_res;
   logic [AW-1:0]     pend_base;
   logic [2:0]        pend_size;

   assign bus.wb_ready = (state == S_IDLE) || !pend_vld;

   always_comb begin
      ld_res  = bus.wb_result;
      ld_base = bus.wb_base;
      ld_size = bus.wb_size;
      ld_go   = 1'b0;
      if (state == S_IDLE) begin
         ld_go = bus.wb_valid;
      end else if (state == S_DONE) begin
         // A parked request wins; the buffer is full so any new strobe is dropped.
         if (pend_vld) begin
            ld_res  = pend_res;
            ld_base = pend_base;
            ld_size = pend_size;
            ld_go   = 1'b1;
         end else begin
            ld_go = bus.wb_valid;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_vld  <= 1'b0;
         pend_res  <= '0;
         pend_base <= '0;
         pend_size <= '0;
      end else if (state == S_WRITE && bus.wb_valid && !pend_vld) begin
         pend_vld  <= 1'b1;
         pend_res  <= bus.wb_result;
         pend_base <= bus.wb_base;
         pend_size <= bus.wb_size;
      end else if (state == S_DONE && pend_vld) begin
         pend_vld  <= 1'b0;
      end
   end
`else
   assign bus.wb_ready = (state == S_IDLE);

   always_comb begin
      ld_res  = bus.wb_result;
      ld_base = bus.wb_base;
      ld_size = bus.wb_size;
      ld_go   = (state == S_IDLE) && bus.wb_valid;
   end
`endif

   assign drop     = bus.wb_valid && !bus.wb_ready;
   assign in_write = (state == S_WRITE);
   assign last_col = (col_q == n_q - 3'd1);
   assign last_row = (row_q == n_q - 3'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         res_q  <= '0;
         base_q <= '0;
         n_q    <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (ld_go) begin
                  res_q  <= ld_res;
                  base_q <= ld_base;
                  n_q    <= eff_n(ld_size);
                  row_q  <= '0;
                  col_q  <= '0;
                  state  <= S_WRITE;
               end else begin
                  state  <= S_IDLE;
               end
            end
            S_WRITE: begin
               if (bus.mem_ready) begin
                  if (last_col) begin
                     col_q <= '0;
                     if (last_row)
                        state <= S_DONE;
                     else
                        row_q <= row_q + 3'd1;
                  end else begin
                     col_q <= col_q + 3'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // A new drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow_q <= 1'b0;
      else if (drop)
         overflow_q <= 1'b1;
      else if (bus.ovf_clr)
         overflow_q <= 1'b0;
   end

   assign idx = IW'(row_q) * IW'(DIM) + IW'(col_q);

   assign bus.mem_wr_en   = in_write;
   assign bus.mem_wr_addr = in_write ? base_q + AW'(idx) : '0;
   assign bus.mem_wr_data = in_write ? res_q[EW*idx +: EW] : '0;
   assign bus.busy        = in_write;
   assign bus.done        = (state == S_DONE);
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_matrix_writeback.sv
// Directed bench for matrix_writeback: full/sub matrix, backpressure, wrap/clamp, overflow, async reset.
module tb_matrix_writeback;
   localparam int DIM = 5, EW = 8, AW = 8, DATA_W = 200;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   matrix_writeback_if #(.DIM(DIM), .EW(EW), .AW(AW), .DATA_W(DATA_W)) bus();
   matrix_writeback #(.DIM(DIM), .EW(EW), .AW(AW), .DATA_W(DATA_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int acc_cyc;
   int wr_addr[$], wr_data[$], wr_cyc[$], st_addr[$], st_data[$], done_cyc[$];
   logic [DATA_W-1:0] mat;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         if (bus.mem_wr_en && bus.mem_ready) begin
            wr_addr.push_back(int'(bus.mem_wr_addr));
            wr_data.push_back(int'(bus.mem_wr_data));
            wr_cyc.push_back(cyc);
         end
         if (bus.mem_wr_en && !bus.mem_ready) begin
            st_addr.push_back(int'(bus.mem_wr_addr));
            st_data.push_back(int'(bus.mem_wr_data));
         end
         if (bus.done) done_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic [2:0] sz, input logic [7:0] base);
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      st_addr.delete(); st_data.delete(); done_cyc.delete();
      @(posedge clk); #1;
      bus.wb_result = mat;
      bus.wb_size   = sz;
      bus.wb_base   = base;
      bus.wb_valid  = 1'b1;
      acc_cyc       = cyc + 1;
      @(posedge clk); #1;
      // Scramble the request inputs to show the latched copy is used.
      bus.wb_valid  = 1'b0;
      bus.wb_result = ~mat;
      bus.wb_base   = 8'hAA;
      bus.wb_size   = 3'd1;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (done_cyc.size() > 0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done seen", 32'(seen), 32'd1);
   endtask

   task automatic check_seq(input string name, input int ea[$], input int ed[$]);
      chk({name, " count"}, wr_addr.size(), ea.size());
      for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
         chk($sformatf("%s addr %0d", name, i), wr_addr[i], ea[i]);
         chk($sformatf("%s data %0d", name, i), wr_data[i], ed[i]);
      end
   endtask

   task automatic wait_writes(input int n);
      for (int i = 0; i < 100 && wr_addr.size() < n; i++) begin
         @(negedge clk); #1;
      end
      chk("write count reached", 32'(wr_addr.size() >= n), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int ea[$], ed[$];
      bus.wb_valid  = 1'b0;
      bus.wb_result = '0;
      bus.wb_size   = 3'd0;
      bus.wb_base   = '0;
      bus.mem_ready = 1'b1;
      bus.ovf_clr   = 1'b0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            mat[EW*(r*DIM+c) +: EW] = 8'(r*DIM + c + 1);

      // Reset values
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst mem_wr_en", bus.mem_wr_en, 0);
      chk("rst addr", bus.mem_wr_addr, 0);
      chk("rst data", bus.mem_wr_data, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst overflow", bus.overflow, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("wb_ready after reset", bus.wb_ready, 1);

      // Full 5x5 at 0x10
      start_req(3'd5, 8'h10);
      wait_done();
      ea.delete(); ed.delete();
      for (int i = 0; i < 25; i++) begin ea.push_back(16 + i); ed.push_back(i + 1); end
      check_seq("full", ea, ed);
      if (wr_cyc.size() == 25) begin
         chk("first write latency", wr_cyc[0], acc_cyc);
         for (int i = 1; i < 25; i++) chk($sformatf("full consecutive %0d", i), wr_cyc[i], wr_cyc[0] + i);
         chk("done after last write", done_cyc[0], wr_cyc[24] + 1);
      end
      chk("done cycle busy", bus.busy, 0);
      chk("done cycle wb_ready", bus.wb_ready, 0);
      @(negedge clk); #1;
      chk("idle wb_ready", bus.wb_ready, 1);
      chk("idle done", bus.done, 0);
      chk("idle busy", bus.busy, 0);

      // 2x2 sub-matrix at 0x00
      start_req(3'd2, 8'h00);
      wait_done();
      check_seq("sub", '{8'h00, 8'h01, 8'h05, 8'h06}, '{1, 2, 6, 7});
      chk("sub done pulses", done_cyc.size(), 1);

      // Backpressure on third write (3x3 at 0x20)
      start_req(3'd3, 8'h20);
      wait_writes(2);
      @(posedge clk); #1 bus.mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.mem_ready = 1'b1;
      wait_done();
      chk("stall count", st_addr.size(), 3);
      for (int i = 0; i < st_addr.size(); i++) begin
         chk($sformatf("stall addr %0d", i), st_addr[i], 32'h22);
         chk($sformatf("stall data %0d", i), st_data[i], 3);
      end
      check_seq("bp", '{8'h20, 8'h21, 8'h22, 8'h25, 8'h26, 8'h27, 8'h2A, 8'h2B, 8'h2C},
                '{1, 2, 3, 6, 7, 8, 11, 12, 13});

      // Wrap past 0xFF with size 0 clamped to 5
      start_req(3'd0, 8'hFE);
      wait_done();
      ea.delete(); ed.delete();
      for (int i = 0; i < 25; i++) begin ea.push_back((254 + i) % 256); ed.push_back(i + 1); end
      check_seq("wrap", ea, ed);

      // Size 7 clamps to 5
      start_req(3'd7, 8'h00);
      wait_done();
      chk("clamp7 count", wr_addr.size(), 25);
      if (wr_addr.size() == 25) chk("clamp7 last addr", wr_addr[24], 32'h18);

      // Overflow: second strobe during WRITE is dropped
      start_req(3'd5, 8'h10);
      repeat (3) @(posedge clk);
      #1;
      bus.wb_valid  = 1'b1;
      bus.wb_base   = 8'h80;
      bus.wb_result = mat;
      @(posedge clk); #1 bus.wb_valid = 1'b0;
      chk("overflow set", bus.overflow, 1);
      wait_done();
      ea.delete(); ed.delete();
      for (int i = 0; i < 25; i++) begin ea.push_back(16 + i); ed.push_back(i + 1); end
      repeat (4) @(negedge clk);
      check_seq("ovf", ea, ed);
      chk("overflow sticky", bus.overflow, 1);
      @(posedge clk); #1 bus.ovf_clr = 1'b1;
      @(negedge clk);
      chk("overflow before clr edge", bus.overflow, 1);
      @(posedge clk); #1 bus.ovf_clr = 1'b0;
      chk("overflow cleared", bus.overflow, 0);

      // Async reset during the 10th write
      start_req(3'd5, 8'h10);
      wait_writes(10);
      #1 reset = 1'b0;
      #1;
      chk("arst mem_wr_en", bus.mem_wr_en, 0);
      chk("arst addr", bus.mem_wr_addr, 0);
      chk("arst data", bus.mem_wr_data, 0);
      chk("arst busy", bus.busy, 0);
      chk("arst done", bus.done, 0);
      chk("arst wb_ready", bus.wb_ready, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      start_req(3'd2, 8'h40);
      wait_done();
      check_seq("post-reset", '{8'h40, 8'h41, 8'h45, 8'h46}, '{1, 2, 6, 7});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
